multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle control FSM for the 16-bit lab CPU datapath. It sequences fetch, decode, execute, memory and write-back for each instruction. It drives every mux select, enable and ALU-operation line of the shared datapath, and selects sign- or zero-extension of the 8-bit immediate feeding the ALU. It stalls on a single-port memory handshake and counts retired instructions.

## Interface
- `MEM_WAIT_MAX`, default 15: cycles to wait for `mem_ready` before flagging `mem_timeout`.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 4: IR[15:12], valid from DECODE onward.
- `funct` in 3: IR[2:0], R-type ALU function.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current read or write this cycle.
- `pc_write`, `pc_write_cond`, `ir_write`, `mem_read`, `mem_write`, `reg_write` out 1: enables.
- `iord` out 1: 0 = PC addresses memory, 1 = ALUOut addresses memory.
- `reg_dst` out 1: 1 = rd field, 0 = rt field.
- `mem_to_reg` out 1: write-back source (1 = MDR).
- `alu_src_a` out 1: 0 = PC, 1 = regA.
- `alu_src_b` out 2: 0 regB, 1 const 1, 2 extended imm8.
- `alu_op` out 3: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 use `funct`.
- `pc_src` out 2: 0 ALU result, 1 ALUOut, 2 jump target.
- `ext_sel` out 1: 1 = sign-extend imm8 (replicate bit 7 into [15:8]), 0 = zero-extend.
- `halted`, `illegal`, `mem_timeout` out 1: status.
- `instr_count` out 16: retired-instruction counter.

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, HALT.
- All outputs are Moore outputs decoded from state. Outside the states listed, every enable is 0, selects are 0 and `ext_sel` = 1.
- FETCH: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=ADD. When `mem_ready`=1, assert `ir_write`, `pc_write` (`pc_src`=0) and go to DECODE. Otherwise stay.
- DECODE, by opcode:
  - 0000 R → EXEC_R.
  - 0001 ADDI, 0010 ANDI → EXEC_I.
  - 0011 LW, 0100 SW → ADDR.
  - 0101 BEQ → BRANCH.
  - 0110 J → JUMP.
  - 1111 HALT → HALT.
  - Any other opcode: pulse `illegal` for that cycle, retire the instruction, go to FETCH.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=4 → WB_ALU with `reg_dst`=1.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=2. ADDI uses `ext_sel`=1, `alu_op`=ADD. ANDI uses `ext_sel`=0, `alu_op`=AND. Next state WB_ALU with `reg_dst`=0.
- ADDR: `alu_src_a`=1, `alu_src_b`=2, `ext_sel`=1, ADD → MEM_RD for LW, MEM_WR for SW.
- MEM_RD / MEM_WR: hold `mem_read`/`mem_write` with `iord`=1 until `mem_ready`.
  - MEM_RD then → WB_MEM.
  - MEM_WR then retires the instruction → FETCH.
- WB_ALU: `reg_write`=1, `mem_to_reg`=0. WB_MEM: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Both retire → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=0, SUB, `pc_write_cond`=1, `pc_src`=1 (ALUOut holds PC+sext(imm8), computed in DECODE with `alu_src_a`=0, `alu_src_b`=2, `ext_sel`=1, ADD). Retire → FETCH.
- JUMP: `pc_write`=1, `pc_src`=2. Retire → FETCH.
- HALT: `halted`=1. Stay in HALT until `rst`. `instr_count` increments once on entry.
- Wait counter: counts cycles spent in FETCH/MEM_RD/MEM_WR while `mem_ready`=0. Clears on state exit.
  - When it reaches `MEM_WAIT_MAX`, set sticky `mem_timeout` and go to HALT.
- `instr_count` increments on each retire. It wraps from 0xFFFF to 0x0000.

## Timing
- Reset (synchronous): state=FETCH, `instr_count`=0, wait counter=0, `mem_timeout`=0, `halted`=0, `illegal`=0. All enables are 0 during the reset cycle.
- Zero-wait latency (`mem_ready` high in FETCH and MEM):
  - R/ADDI/ANDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ, J: 3 cycles.
  - Illegal: 2 cycles.
- Each cycle of `mem_ready`=0 adds one cycle. `ir_write` and the PC+1 `pc_write` occur only in the cycle `mem_ready`=1.
- `rst` mid-instruction aborts it. The next cycle is FETCH, and no write enable is asserted in the reset cycle.
- `mem_ready`=1 outside memory states is ignored.

## Test plan
- Reset, then R-type with `mem_ready` tied 1 → states FETCH, DECODE, EXEC_R, WB_ALU. `reg_write`=1, `reg_dst`=1 in cycle 4. `instr_count`=1.
- ADDI then ANDI → `ext_sel`=1 in EXEC_I for ADDI and 0 for ANDI. `alu_src_b`=2 in both.
- LW with `mem_ready` low 3 cycles in MEM_RD → `mem_read`=1 and `iord`=1 held 4 cycles, then WB_MEM with `mem_to_reg`=1. Total 8 cycles.
- BEQ with `zero`=1 and J → `pc_write_cond`=1 with `pc_src`=1 in BRANCH, and `pc_write`=1 with `pc_src`=2 in JUMP. Each takes 3 cycles.
- Opcode 0111 → `illegal` pulses 1 cycle in DECODE, FETCH follows, `instr_count`+1. Opcode 1111 → `halted`=1 held for 20 cycles, no further enables.
- `mem_ready` held 0 in FETCH → `mem_timeout`=1 after 15 wait cycles, then HALT. Assert `rst` mid-LW → FETCH next cycle with counters cleared. Preload 0xFFFF retires → `instr_count` wraps to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 16-bit lab CPU datapath.
// Sequences fetch/decode/execute/memory/write-back, drives every datapath
// select and enable as a Moore decode of the current state, waits on a
// single-port memory handshake and counts retired instructions.
//
// Handshake: mem_read/mem_write (with iord) are held for as long as the FSM
// sits in FETCH/MEM_RD/MEM_WR; the access completes in the cycle where
// mem_ready=1 is seen alongside the request, and the FSM leaves the state on
// that edge. mem_ready outside those states has no effect.
module multicycle_control #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  opcode,
  input  logic [2:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        iord,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic        ext_sel,
  output logic        halted,
  output logic        illegal,
  output logic        mem_timeout,
  output logic [15:0] instr_count,
  output logic [3:0]  dbg_state_o
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    EXEC_I = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    MEM_WR = 4'd6,
    WB_ALU = 4'd7,
    WB_MEM = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    HALT   = 4'd11
  } state_t;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_ANDI = 4'b0010;
  localparam logic [3:0] OP_LW   = 4'b0011;
  localparam logic [3:0] OP_SW   = 4'b0100;
  localparam logic [3:0] OP_BEQ  = 4'b0101;
  localparam logic [3:0] OP_J    = 4'b0110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_FUNCT = 3'd4;

  localparam int WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                timeout_q, timeout_d;
  logic [15:0]         count_q, count_d;
  logic                retire;
  logic                op_legal;
  logic                in_mem_wait;

  // funct feeds the ALU control and zero gates pc_write_cond in the datapath;
  // the FSM itself never needs to look at either.
  logic unused_inputs;
  assign unused_inputs = ^{funct, zero};

  assign op_legal = (opcode == OP_R)   || (opcode == OP_ADDI) ||
                    (opcode == OP_ANDI) || (opcode == OP_LW)  ||
                    (opcode == OP_SW)  || (opcode == OP_BEQ)  ||
                    (opcode == OP_J)   || (opcode == OP_HALT);

  assign in_mem_wait = ((state_q == FETCH) || (state_q == MEM_RD) ||
                        (state_q == MEM_WR)) && !mem_ready;

  // State, wait counter, sticky timeout and retire counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      count_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  // Next-state, retire detection and memory wait/timeout tracking.
  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    wait_d    = '0;
    timeout_d = timeout_q;
    case (state_q)
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:            state_d = EXEC_R;
          OP_ADDI, OP_ANDI: state_d = EXEC_I;
          OP_LW, OP_SW:    state_d = ADDR;
          OP_BEQ:          state_d = BRANCH;
          OP_J:            state_d = JUMP;
          OP_HALT: begin
            state_d = HALT;
            retire  = 1'b1;
          end
          default: begin
            state_d = FETCH;
            retire  = 1'b1;
          end
        endcase
      end
      EXEC_R, EXEC_I: state_d = WB_ALU;
      ADDR:   state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD: if (mem_ready) state_d = WB_MEM;
      MEM_WR: begin
        if (mem_ready) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      WB_ALU, WB_MEM, BRANCH, JUMP: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
    // A stalled access that reaches the limit abandons the instruction.
    if (in_mem_wait) begin
      if (wait_q == WAIT_LAST) begin
        timeout_d = 1'b1;
        state_d   = HALT;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end
    count_d = retire ? count_q + 16'd1 : count_q;
  end

  // Moore decode of datapath controls; everything is idle in the reset cycle.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    iord          = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = ALU_ADD;
    pc_src        = 2'd0;
    ext_sel       = 1'b1;
    halted        = 1'b0;
    illegal       = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'd1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        DECODE: begin
          // Branch target PC+sext(imm8) is parked in ALUOut here.
          alu_src_b = 2'd2;
          illegal   = !op_legal;
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          if (opcode == OP_ANDI) begin
            ext_sel = 1'b0;
            alu_op  = ALU_AND;
          end
        end
        ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        WB_ALU: begin
          reg_write = 1'b1;
          reg_dst   = (opcode == OP_R);
        end
        WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_src        = 2'd1;
        end
        JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign mem_timeout = timeout_q;
  assign instr_count = count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control.
module tb_multicycle_control;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_EXEC_I = 4'd3;
  localparam logic [3:0] S_ADDR   = 4'd4;
  localparam logic [3:0] S_MEM_RD = 4'd5;
  localparam logic [3:0] S_MEM_WR = 4'd6;
  localparam logic [3:0] S_WB_ALU = 4'd7;
  localparam logic [3:0] S_WB_MEM = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_HALT   = 4'd11;

  // enable vector order: {pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write}
  localparam logic [5:0] EN_NONE  = 6'b000000;
  localparam logic [5:0] EN_FETCH = 6'b101100;
  localparam logic [5:0] EN_FWAIT = 6'b000100;
  localparam logic [5:0] EN_MRD   = 6'b000100;
  localparam logic [5:0] EN_MWR   = 6'b000010;
  localparam logic [5:0] EN_WB    = 6'b000001;
  localparam logic [5:0] EN_BR    = 6'b010000;
  localparam logic [5:0] EN_JMP   = 6'b100000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  opcode;
  logic [2:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write;
  logic        iord, reg_dst, mem_to_reg, alu_src_a, ext_sel;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_op;
  logic        halted, illegal, mem_timeout;
  logic [15:0] instr_count;
  logic [3:0]  dbg_state;
  logic [5:0]  en;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_cnt;

  assign en = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write};

  multicycle_control #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .iord(iord), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .ext_sel(ext_sel), .halted(halted), .illegal(illegal),
    .mem_timeout(mem_timeout), .instr_count(instr_count),
    .dbg_state_o(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inputs are driven at the falling edge; outputs are checked 1 time unit later.
  task automatic look(input string tag, input logic [3:0] st, input logic [5:0] e);
    #1;
    check({tag, "/state"}, 32'(dbg_state), 32'(st));
    check({tag, "/en"}, 32'(en), 32'(e));
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic fetch_decode(input string tag, input logic [3:0] op, input logic exp_ill);
    opcode    = op;
    mem_ready = 1'b1;
    look({tag, "/fetch"}, S_FETCH, EN_FETCH);
    check({tag, "/fetch_srcb"}, 32'(alu_src_b), 32'd1);
    check({tag, "/fetch_iord"}, 32'(iord), 32'd0);
    check({tag, "/fetch_aluop"}, 32'(alu_op), 32'd0);
    check({tag, "/count_start"}, 32'(instr_count), 32'(exp_cnt));
    next();
    look({tag, "/decode"}, S_DECODE, EN_NONE);
    check({tag, "/decode_srca"}, 32'(alu_src_a), 32'd0);
    check({tag, "/decode_srcb"}, 32'(alu_src_b), 32'd2);
    check({tag, "/decode_ext"}, 32'(ext_sel), 32'd1);
    check({tag, "/decode_ill"}, 32'(illegal), 32'(exp_ill));
    next();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mem_ready = 1'b1;
    next();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; opcode = 4'h0; funct = 3'd0; zero = 1'b0; mem_ready = 1'b1;
    exp_cnt = 16'h0000;
    next();
    // reset cycle: FSM is in FETCH with mem_ready high, yet nothing may fire
    look("reset", S_FETCH, EN_NONE);
    check("reset/halted", 32'(halted), 32'd0);
    check("reset/illegal", 32'(illegal), 32'd0);
    check("reset/timeout", 32'(mem_timeout), 32'd0);
    check("reset/count", 32'(instr_count), 32'd0);
    next();
    rst = 1'b0;

    // R-type
    fetch_decode("r", 4'b0000, 1'b0);
    look("r/exec", S_EXEC_R, EN_NONE);
    check("r/srca", 32'(alu_src_a), 32'd1);
    check("r/srcb", 32'(alu_src_b), 32'd0);
    check("r/aluop", 32'(alu_op), 32'd4);
    next();
    look("r/wb", S_WB_ALU, EN_WB);
    check("r/regdst", 32'(reg_dst), 32'd1);
    check("r/m2r", 32'(mem_to_reg), 32'd0);
    next();
    exp_cnt = 16'd1;

    // ADDI
    fetch_decode("addi", 4'b0001, 1'b0);
    look("addi/exec", S_EXEC_I, EN_NONE);
    check("addi/ext", 32'(ext_sel), 32'd1);
    check("addi/srcb", 32'(alu_src_b), 32'd2);
    check("addi/aluop", 32'(alu_op), 32'd0);
    next();
    look("addi/wb", S_WB_ALU, EN_WB);
    check("addi/regdst", 32'(reg_dst), 32'd0);
    next();
    exp_cnt = 16'd2;

    // ANDI
    fetch_decode("andi", 4'b0010, 1'b0);
    look("andi/exec", S_EXEC_I, EN_NONE);
    check("andi/ext", 32'(ext_sel), 32'd0);
    check("andi/srcb", 32'(alu_src_b), 32'd2);
    check("andi/aluop", 32'(alu_op), 32'd2);
    next();
    look("andi/wb", S_WB_ALU, EN_WB);
    check("andi/regdst", 32'(reg_dst), 32'd0);
    next();
    exp_cnt = 16'd3;

    // LW with three stalled memory cycles: 8 cycles total
    fetch_decode("lw", 4'b0011, 1'b0);
    look("lw/addr", S_ADDR, EN_NONE);
    check("lw/addr_srcb", 32'(alu_src_b), 32'd2);
    check("lw/addr_ext", 32'(ext_sel), 32'd1);
    next();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      look("lw/mem", S_MEM_RD, EN_MRD);
      check("lw/iord", 32'(iord), 32'd1);
      next();
    end
    mem_ready = 1'b1;
    look("lw/wb", S_WB_MEM, EN_WB);
    check("lw/m2r", 32'(mem_to_reg), 32'd1);
    check("lw/regdst", 32'(reg_dst), 32'd0);
    next();
    exp_cnt = 16'd4;

    // SW zero-wait
    fetch_decode("sw", 4'b0100, 1'b0);
    look("sw/addr", S_ADDR, EN_NONE);
    next();
    look("sw/mem", S_MEM_WR, EN_MWR);
    check("sw/iord", 32'(iord), 32'd1);
    next();
    exp_cnt = 16'd5;

    // BEQ with zero set
    zero = 1'b1;
    fetch_decode("beq", 4'b0101, 1'b0);
    look("beq/br", S_BRANCH, EN_BR);
    check("beq/pcsrc", 32'(pc_src), 32'd1);
    check("beq/aluop", 32'(alu_op), 32'd1);
    check("beq/srca", 32'(alu_src_a), 32'd1);
    check("beq/srcb", 32'(alu_src_b), 32'd0);
    next();
    zero = 1'b0;
    exp_cnt = 16'd6;

    // J
    fetch_decode("j", 4'b0110, 1'b0);
    look("j/jump", S_JUMP, EN_JMP);
    check("j/pcsrc", 32'(pc_src), 32'd2);
    next();
    exp_cnt = 16'd7;

    // illegal opcode: two cycles, retired
    fetch_decode("ill", 4'b0111, 1'b1);
    look("ill/after", S_FETCH, EN_FETCH);
    check("ill/pulse_off", 32'(illegal), 32'd0);
    check("ill/count", 32'(instr_count), 32'd8);

    // LW aborted by reset after three stalled cycles in MEM_RD
    exp_cnt = 16'd8;
    fetch_decode("lwrst", 4'b0011, 1'b0);
    look("lwrst/addr", S_ADDR, EN_NONE);
    next();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      look("lwrst/mem", S_MEM_RD, EN_MRD);
      next();
    end
    rst = 1'b1;
    mem_ready = 1'b1;
    look("lwrst/rstcyc", S_MEM_RD, EN_NONE);
    next();
    rst = 1'b0;
    exp_cnt = 16'd0;

    // FETCH starved: 15 wait cycles then timeout into HALT
    mem_ready = 1'b0;
    check("abort/count", 32'(instr_count), 32'd0);
    for (int i = 1; i <= 15; i++) begin
      look("tmo/wait", S_FETCH, EN_FWAIT);
      check("tmo/flag_low", 32'(mem_timeout), 32'd0);
      next();
    end
    for (int i = 0; i < 3; i++) begin
      look("tmo/halt", S_HALT, EN_NONE);
      check("tmo/flag", 32'(mem_timeout), 32'd1);
      check("tmo/halted", 32'(halted), 32'd1);
      next();
    end
    do_reset();
    #1;
    check("tmo/flag_cleared", 32'(mem_timeout), 32'd0);

    // HALT opcode: retires once, then idle for 20 cycles
    fetch_decode("halt", 4'b1111, 1'b0);
    for (int i = 0; i < 20; i++) begin
      look("halt/hold", S_HALT, EN_NONE);
      check("halt/halted", 32'(halted), 32'd1);
      check("halt/count", 32'(instr_count), 32'd1);
      next();
    end
    do_reset();

    // counter wrap: preload 0xFFFF while FETCH stalls, then retire a J
    mem_ready = 1'b0;
    force dut.count_q = 16'hFFFF;
    look("wrap/stall", S_FETCH, EN_FWAIT);
    next();
    release dut.count_q;
    look("wrap/stall2", S_FETCH, EN_FWAIT);
    next();
    exp_cnt = 16'hFFFF;
    fetch_decode("wrap", 4'b0110, 1'b0);
    look("wrap/jump", S_JUMP, EN_JMP);
    next();
    look("wrap/after", S_FETCH, EN_FETCH);
    check("wrap/count", 32'(instr_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // hard time limit so a wedged run still reports
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
